// File: rtl/fetch_unit_pkg.sv
// Shared constants and the prefetch-queue entry type for the fetch unit.
// PC fields are sized for the widest supported XLEN (64); narrower PCs are zero-extended.
package fetch_unit_pkg;

    localparam int ILEN     = 32;
    localparam int PC_INC   = 4;
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [ILEN-1:0]     inst;
    } q_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; head is visible combinationally.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full      = (count_q == (AW+1)'(DEPTH));
        empty     = (count_q == '0);
        count     = count_q;
        head_data = mem_q[rd_ptr_q];
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order tag FIFO,
// prefetch queue to decode, and redirect flush with stale-response discard.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [ILEN-1:0]   imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [ILEN-1:0]   inst_data,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   tag_count, q_count;
    logic            tag_full, tag_empty, q_full, q_empty;
    logic [XLEN-1:0] tag_pc;
    q_entry_t        q_push_data, q_head;
    logic [SW-1:0]   in_flight;
    logic            req_fire, rsp_drop, rsp_accept, inst_fire;

    // Credits cover queued instructions, live tags and responses still to be discarded.
    always_comb begin
        in_flight        = SW'(q_count) + SW'(tag_count) + SW'(discard_q);
        imem_req_valid   = reset && !redirect_valid && (in_flight < SW'(DEPTH));
        imem_req_addr    = fetch_pc_q;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_drop         = imem_rsp_valid && (redirect_valid || (discard_q != '0));
        rsp_accept       = imem_rsp_valid && !rsp_drop;
        inst_valid       = !q_empty;
        inst_fire        = inst_valid && inst_ready;
        inst_data        = inst_valid ? q_head.inst : '0;
        inst_pc          = inst_valid ? q_head.pc[XLEN-1:0] : '0;
        q_push_data.pc   = PC_MAX_W'(tag_pc);
        q_push_data.inst = imem_rsp_data;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // Every response still owed becomes a discard, minus one arriving right now.
            discard_d  = discard_q + tag_count + CW'(req_fire) - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
            if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_accept),
        .flush     (redirect_valid),
        .head_data (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    sync_fifo #(.WIDTH($bits(q_entry_t)), .DEPTH(DEPTH)) u_pf_queue (
        .clk       (clk),
        .rst_n     (reset),
        .push      (rsp_accept),
        .push_data (q_push_data),
        .pop       (inst_fire),
        .flush     (redirect_valid),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            if (imem_rsp_valid) assert ((discard_q != '0) || !tag_empty);
            assert (!(req_fire && tag_full));
            assert (!(rsp_accept && q_full && !inst_fire));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, data}; a negedge
// monitor pops and compares every instruction decode accepts.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.XLEN(64), .DEPTH(4), .RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct { logic [63:0] addr; int due; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;

    req_t        pend[$];
    exp_t        exp_q[$];
    int          cons_cyc[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fires = 0;
    int          granted = 0;
    int          rel_cyc = 0;
    logic        hold = 1'b0;
    logic        limit_en = 1'b0;
    logic        rand_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] pc;
            pc = start + 64'(4 * i);
            exp_q.push_back('{pc, memf(pc)});
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Memory model and decode-ready driver, updated just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (reset !== 1'b1) begin
            pend.delete();
        end else if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
            pend.delete(0);
        end
        if (limit_en)       imem_req_ready = (granted < 3);
        else if (rand_mode) imem_req_ready = ($urandom_range(0, 3) != 0);
        else                imem_req_ready = 1'b1;
        inst_ready = (exp_q.size() > 0) && (!rand_mode || ($urandom_range(0, 1) == 1));
    end

    // Monitor: request acceptance, address stability, and decode-side scoreboard.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            if (imem_req_valid) begin
                if (stall_prev) check("req_addr_stable", imem_req_addr, stall_addr);
                if (imem_req_ready) begin
                    int lat;
                    lat = rand_mode ? int'($urandom_range(1, 3)) : 1;
                    check("req_addr_align", 64'(imem_req_addr[1:0]), 64'd0);
                    pend.push_back('{imem_req_addr, cyc + lat});
                    fires++;
                    granted++;
                end
            end
            stall_prev = imem_req_valid && !imem_req_ready;
            stall_addr = imem_req_addr;
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst actual_pc=%h required=none", inst_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_data", 64'(inst_data), 64'(e.data));
                    cons_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;

        // Reset state, then fill timing and steady streaming.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_inst_data", 64'(inst_data), 64'd0);
        @(posedge clk);
        push_exp(64'h1000, 8);
        #2 reset = 1'b1;
        rel_cyc = cyc;
        cons_cyc.delete();
        wait_drain(60);
        if (cons_cyc.size() >= 3) begin
            for (int i = 0; i < 3; i++)
                check("fill_timing", 64'(cons_cyc[i]), 64'(rel_cyc + 2 + i));
        end else begin
            checks++;
            failures++;
            $display("FAIL fill_timing actual_consumed=%0d required=3", cons_cyc.size());
        end

        // Decode stalled: credit limit stops requests at queue depth.
        #2 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        fires = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_fires", 64'(fires), 64'd4);
        check("stall_req_valid", 64'(imem_req_valid), 64'd0);
        check("stall_inst_valid", 64'(inst_valid), 64'd1);
        check("stall_inst_pc", inst_pc, 64'h1000);
        check("stall_inst_data", 64'(inst_data), 64'(memf(64'h1000)));

        // Asynchronous reset with the queue full.
        #1 reset = 1'b0;
        #1;
        check("async_req_valid", 64'(imem_req_valid), 64'd0);
        check("async_inst_valid", 64'(inst_valid), 64'd0);
        check("async_inst_pc", inst_pc, 64'd0);
        check("async_inst_data", 64'(inst_data), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        push_exp(64'h1000, 6);
        @(negedge clk);
        check("restart_req_valid", 64'(imem_req_valid), 64'd1);
        check("restart_req_addr", imem_req_addr, 64'h1000);
        wait_drain(60);

        // Redirect to a misaligned target with three requests outstanding.
        #2 reset = 1'b0;
        hold = 1'b1;
        limit_en = 1'b1;
        granted = 0;
        fires = 0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (6) @(posedge clk);
        check("outstanding_reqs", 64'(fires), 64'd3);
        #2 redirect_valid = 1'b1;
        redirect_pc = 64'h2002;
        push_exp(64'h2000, 5);
        @(negedge clk);
        check("redir_req_valid", 64'(imem_req_valid), 64'd0);
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        hold = 1'b0;
        limit_en = 1'b0;
        @(negedge clk);
        check("redir_req_addr", imem_req_addr, 64'h2000);
        check("redir_req_valid_next", 64'(imem_req_valid), 64'd1);
        check("redir_inst_valid", 64'(inst_valid), 64'd0);
        wait_drain(60);

        // Fetch PC wrap at the top of the address space.
        #2 redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        push_exp(64'hFFFF_FFFF_FFFF_FFFC, 4);
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_inst_valid", 64'(inst_valid), 64'd0);
        wait_drain(60);

        // Random memory readiness, latency and decode backpressure.
        #2 reset = 1'b0;
        rand_mode = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        push_exp(64'h1000, 40);
        wait_drain(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
